boot_readback: RTL and testbench
================================

Name: boot_readback

Overview:
- Native-bus read master that walks a word-aligned region of internal SRAM after the boot controller has loaded it.
- Accumulates a 32-bit additive checksum over the region so firmware can confirm the loaded image.
- Sits beside the boot controller on the data-bus split.
- Its CPU slave side is a 4-register block; its master side connects, through the instruction-bus merge, to the SRAM read port.

Parameters:
ADDR_W, 32, byte-address width of the SRAM master interface
DATA_W, 32, data width; checksum width equals DATA_W

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
cpu_valid  input  1  CPU request strobe
cpu_addr  input  2  word register select
cpu_wdata  input  DATA_W  CPU write data
cpu_wstrb  input  DATA_W/8  write strobes; nonzero = write, zero = read
cpu_rdata  output  DATA_W  register read data
cpu_ready  output  1  CPU request complete
sram_valid  output  1  SRAM read request
sram_addr  output  ADDR_W  SRAM byte address, bits [1:0] always 0
sram_rdata  input  DATA_W  SRAM read data
sram_ready  input  1  SRAM read complete; sram_rdata valid this cycle
busy  output  1  scan in progress
done  output  1  scan finished, sticky until next start

Behaviour:
- Clock and reset: single clock clk; rst asynchronous active-high. On reset all outputs and registers are 0 and the FSM is in IDLE.
- Register map (cpu_addr):
  - 0 BASE (rw): start byte address; bits [1:0] are forced to 0 on write.
  - 1 COUNT (rw): word count. A write while IDLE or DONE loads the count and starts a scan.
  - 2 STATUS: read gives {mismatch, done, busy} in bits [2:0], all other bits 0. Write with wdata[0]=1 aborts.
  - 3 CHECKSUM (r): current checksum value.
- CPU handshake:
  - cpu_ready pulses exactly one cycle after any cpu_valid cycle.
  - cpu_rdata is registered and valid only while cpu_ready=1; it is 0 otherwise.
  - CPU side accepts one request at a time; cpu_valid is a single-cycle strobe.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - A COUNT write with value N>0 clears the checksum to 0, clears done, loads addr_q=BASE and remaining=N, and enters REQ. busy=1 from the next cycle.
  - A COUNT write with N=0 clears the checksum, goes straight to DONE, sets done=1 the next cycle, and issues no SRAM access.
- REQ:
  - sram_valid=1 and sram_addr=addr_q, both held stable until sram_ready.
  - On sram_ready: checksum <= checksum + sram_rdata (mod 2^DATA_W), addr_q <= addr_q+4 (wraps mod 2^ADDR_W), remaining <= remaining-1.
  - If remaining was 1, go to DONE; otherwise stay in REQ with sram_valid still asserted.
  - A zero-wait SRAM therefore sustains 1 word per cycle.
  - Only one outstanding request at a time.
- DONE: busy=0, done=1, sram_valid=0. A COUNT write restarts as from IDLE.
- Abort: a STATUS write with wdata[0]=1 in any state goes to IDLE the next cycle and forces sram_valid=0, busy=0, done=0. The checksum keeps its partial value. If sram_ready arrives in the same cycle as the abort write, that word is still accumulated.
- Writes while busy:
  - BASE and COUNT writes while in REQ are ignored, but still get cpu_ready.
  - Reads are allowed in any state.
- Simultaneous events: a CPU read of CHECKSUM in the same cycle as an accumulate returns the pre-update value.
- Reset mid-scan: sram_valid drops asynchronously and all state clears.

Optional Feature:
Macro BOOT_READBACK_CMP_EN.
- Defined:
  - cpu_addr 3 write loads an EXPECTED register (reset 0).
  - On entry to DONE, mismatch <= (checksum != EXPECTED).
  - mismatch is cleared on start and on abort, and reads at STATUS bit 2.
- Undefined:
  - There is no EXPECTED register; writes to cpu_addr 3 are ignored, but still get cpu_ready.
  - STATUS bit 2 reads 0.

Test Plan:
- Reset: assert rst mid-cycle -> sram_valid, busy, done, cpu_ready all 0 immediately; BASE, COUNT, CHECKSUM and STATUS all read 0.
- Basic scan: BASE=0x100, COUNT=4, zero-wait SRAM returning 1,2,3,0xFFFFFFFF -> addresses 0x100, 0x104, 0x108, 0x10C on consecutive cycles; CHECKSUM=0x00000005; STATUS=0x2.
- Wait states: COUNT=2, sram_ready delayed 3 cycles per word -> sram_valid and sram_addr stable during waits; exactly 2 accumulations.
- Boundaries:
  - COUNT=0 -> done=1 with no sram_valid pulse and CHECKSUM=0.
  - BASE=0xFFFFFFFC with COUNT=2 -> second address 0x00000000.
- Abort and busy writes:
  - STATUS write 0x1 after the 1st of 8 words -> IDLE, busy=0, done=0, sram_valid=0 next cycle.
  - COUNT write during REQ -> ignored; scan completes with the original count.
- BOOT_READBACK_CMP_EN:
  - EXPECTED=0x5 with the basic-scan data -> STATUS=0x2.
  - EXPECTED=0x6 -> STATUS=0x6.
  - Without the macro -> STATUS bit 2 always 0.

Source files
------------

// File: rtl/boot_readback.sv
// SRAM readback master: walks BASE..BASE+4*(COUNT-1) and sums the words read.
// Optional compare against an EXPECTED register under BOOT_READBACK_CMP_EN.
module boot_readback #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_valid,
    input  logic [1:0]          cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    input  logic [DATA_W/8-1:0] cpu_wstrb,
    output logic [DATA_W-1:0]   cpu_rdata,
    output logic                cpu_ready,
    output logic                sram_valid,
    output logic [ADDR_W-1:0]   sram_addr,
    input  logic [DATA_W-1:0]   sram_rdata,
    input  logic                sram_ready,
    output logic                busy,
    output logic                done
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   base_q, addr_q, wdata_a;
    logic [DATA_W-1:0]   count_q, remaining, checksum, rd_mux;
    logic                mismatch;
    logic                cpu_wr, wr_count, wr_abort, start, accum, last;

    assign wdata_a  = ADDR_W'(cpu_wdata);
    assign cpu_wr   = cpu_valid && (|cpu_wstrb);
    assign wr_count = cpu_wr && cpu_addr == 2'd1;
    assign wr_abort = cpu_wr && cpu_addr == 2'd2 && cpu_wdata[0];
    assign start    = wr_count && state != REQ;
    assign accum    = state == REQ && sram_ready;
    assign last     = accum && remaining == DATA_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = (cpu_wdata == '0) ? DONE : REQ;
            REQ:        if (last)  state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
        if (wr_abort) state_nxt = IDLE;
    end

    always_comb begin
        sram_valid = state == REQ;
        busy       = state == REQ;
        done       = state == DONE;
        sram_addr  = addr_q;
    end

    // Abort does not block accumulation: a word landing with the abort still counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q    <= '0;
            addr_q    <= '0;
            count_q   <= '0;
            remaining <= '0;
            checksum  <= '0;
        end else begin
            if (cpu_wr && cpu_addr == 2'd0 && state != REQ)
                base_q <= wdata_a & ~ADDR_W'(3);
            if (start) begin
                count_q   <= cpu_wdata;
                remaining <= cpu_wdata;
                addr_q    <= base_q;
                checksum  <= '0;
            end else if (accum) begin
                checksum  <= checksum + sram_rdata;
                addr_q    <= addr_q + ADDR_W'(4);
                remaining <= remaining - DATA_W'(1);
            end
        end
    end

`ifdef BOOT_READBACK_CMP_EN
    logic [DATA_W-1:0] expected;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            expected <= '0;
            mismatch <= 1'b0;
        end else begin
            if (cpu_wr && cpu_addr == 2'd3) expected <= cpu_wdata;
            if (wr_abort)
                mismatch <= 1'b0;
            else if (start)
                mismatch <= (cpu_wdata == '0) ? (expected != '0) : 1'b0;
            else if (last)
                mismatch <= (checksum + sram_rdata) != expected;
        end
    end
`else
    assign mismatch = 1'b0;
`endif

    always_comb begin
        case (cpu_addr)
            2'd0:    rd_mux = DATA_W'(base_q);
            2'd1:    rd_mux = count_q;
            2'd2:    rd_mux = DATA_W'({mismatch, state == DONE, state == REQ});
            default: rd_mux = checksum;
        endcase
    end

    // Read data is registered and zero outside the ready cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_ready <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            cpu_ready <= cpu_valid;
            cpu_rdata <= (cpu_valid && !cpu_wr) ? rd_mux : '0;
        end
    end
endmodule

// File: tb/tb_boot_readback.sv
// Randomized scoreboard bench for boot_readback with a behavioural SRAM and register model.
// Honors BOOT_READBACK_CMP_EN for the expected STATUS mismatch bit.
module tb_boot_readback;
    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_valid;
    logic [1:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_wstrb;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        sram_valid;
    logic [31:0] sram_addr;
    logic [31:0] sram_rdata;
    logic        sram_ready;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    boot_readback #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_wstrb(cpu_wstrb), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .sram_valid(sram_valid), .sram_addr(sram_addr), .sram_rdata(sram_rdata),
        .sram_ready(sram_ready), .busy(busy), .done(done)
    );

    typedef struct {
        bit          chk;
        logic [1:0]  a;
        logic [31:0] v;
    } rd_t;

    rd_t         rq[$];
    logic [31:0] aq[$];
    logic [31:0] ovr [bit [31:0]];
    int          checks = 0, failures = 0;
    int          credits = 0, wait_cyc = 0, wcnt = 0, hs = 0, bcyc = 0;
    bit          wait_rnd = 1'b0;
    logic [31:0] cur_base, cur_sum, cur_exp;
    int          cur_n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (ovr.exists(a)) return ovr[a];
        return a * 32'h9E3779B1 + 32'h01234567;
    endfunction

    function automatic logic [31:0] sum_of(input logic [31:0] b, input int n);
        logic [31:0] a, s;
        a = b & ~32'h3;
        s = 0;
        for (int i = 0; i < n; i++) begin
            s += mem(a);
            a += 32'd4;
        end
        return s;
    endfunction

    // SRAM: optional wait states and a credit limit to stall it on demand.
    always @(posedge clk) begin
        #2;
        if (sram_ready) begin
            sram_ready = 1'b0;
            wcnt = wait_rnd ? $urandom_range(0, 2) : wait_cyc;
        end
        if (rst || !sram_valid) begin
            sram_ready = 1'b0;
            wcnt = wait_rnd ? $urandom_range(0, 2) : wait_cyc;
        end else if (credits > 0) begin
            if (wcnt == 0) begin
                sram_ready = 1'b1;
                sram_rdata = mem(sram_addr);
                credits--;
            end else begin
                wcnt--;
            end
        end
    end

    always @(negedge clk) begin
        rd_t r;
        if (!rst) begin
            if (busy) bcyc++;
            if (sram_valid) begin
                if (aq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL sram_unexpected actual_addr=%h expected=none", sram_addr);
                end else begin
                    chk("sram_addr", sram_addr, aq[0]);
                    if (sram_ready) begin
                        void'(aq.pop_front());
                        hs++;
                    end
                end
            end
            if (cpu_ready) begin
                if (rq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL cpu_ready_unexpected actual=1 expected=0");
                end else begin
                    r = rq.pop_front();
                    if (r.chk) chk($sformatf("cpu_rdata[%0d]", r.a), cpu_rdata, r.v);
                end
            end else begin
                chk("cpu_rdata_idle", cpu_rdata, 32'h0);
            end
        end
    end

    task automatic cpu_io(input logic [1:0] a, input logic [31:0] wd, input logic [3:0] ws,
                          input bit do_chk, input logic [31:0] exp);
        rd_t r;
        r.chk = do_chk;
        r.a   = a;
        r.v   = exp;
        rq.push_back(r);
        cpu_valid = 1'b1;
        cpu_addr  = a;
        cpu_wdata = wd;
        cpu_wstrb = ws;
        @(posedge clk); #1;
        cpu_valid = 1'b0;
        cpu_wstrb = 4'h0;
        @(posedge clk); #1;
    endtask

    task automatic cpu_rd(input logic [1:0] a, input logic [31:0] exp);
        cpu_io(a, 32'h0, 4'h0, 1'b1, exp);
    endtask

    task automatic cpu_wr(input logic [1:0] a, input logic [31:0] wd);
        cpu_io(a, wd, 4'hF, 1'b0, 32'h0);
    endtask

    task automatic scan_start(input logic [31:0] b, input int n, input logic [31:0] expv);
        logic [31:0] a;
        cur_base = b & ~32'h3;
        cur_n    = n;
        cur_sum  = sum_of(b, n);
        cur_exp  = expv;
        cpu_wr(2'd0, b);
        cpu_wr(2'd3, expv);
        a = cur_base;
        for (int i = 0; i < n; i++) begin
            aq.push_back(a);
            a += 32'd4;
        end
        bcyc = 0;
        hs   = 0;
        cpu_wr(2'd1, n);
    endtask

    task automatic scan_finish(input int exp_bcyc);
        int   c;
        logic mm;
        c = 0;
        while (!done && c < cur_n * 5 + 20) begin
            @(posedge clk); #1;
            c++;
        end
        chk("scan_done", done, 1'b1);
        chk("busy_after", busy, 1'b0);
        chk("sram_valid_after", sram_valid, 1'b0);
        chk("word_count", hs, cur_n);
        chk("addr_queue_left", aq.size(), 0);
        if (exp_bcyc >= 0) chk("busy_cycles", bcyc, exp_bcyc);
`ifdef BOOT_READBACK_CMP_EN
        mm = cur_sum != cur_exp;
`else
        mm = 1'b0;
`endif
        cpu_rd(2'd3, cur_sum);
        cpu_rd(2'd2, {29'h0, mm, 2'b10});
        cpu_rd(2'd1, cur_n);
        cpu_rd(2'd0, cur_base);
        aq.delete();
    endtask

    initial begin
        int c;
        rst = 1'b1; cpu_valid = 1'b0; cpu_addr = 2'd0; cpu_wdata = 32'h0; cpu_wstrb = 4'h0;
        sram_ready = 1'b0; sram_rdata = 32'h0;
        #12 rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_sram_valid", sram_valid, 1'b0);
        for (int i = 0; i < 4; i++) cpu_rd(i[1:0], 32'h0);

        // Basic scan, zero-wait, with a matching and a non-matching EXPECTED.
        ovr[32'h100] = 32'h1; ovr[32'h104] = 32'h2; ovr[32'h108] = 32'h3; ovr[32'h10C] = 32'hFFFFFFFF;
        credits = 100000; wait_cyc = 0;
        scan_start(32'h100, 4, 32'h5);
        scan_finish(4);
        chk("basic_sum_const", cur_sum, 32'h5);
        scan_start(32'h100, 4, 32'h6);
        scan_finish(4);

        // Fixed wait states: 3 idle cycles before each ready.
        wait_cyc = 3;
        scan_start(32'h200, 2, 32'h0);
        scan_finish(8);
        wait_cyc = 0;

        // Zero-length scan and address wraparound.
        scan_start(32'h300, 0, 32'h0);
        scan_finish(0);
        scan_start(32'hFFFFFFFC, 2, 32'h0);
        scan_finish(2);

        // Writes to BASE/COUNT during a scan are ignored.
        wait_cyc = 1;
        scan_start(32'h400, 6, 32'h0);
        cpu_wr(2'd1, 32'd2);
        cpu_wr(2'd0, 32'h500);
        scan_finish(-1);
        wait_cyc = 0;

        // Abort after the first of eight words.
        credits = 1;
        scan_start(32'h700, 8, 32'h0);
        c = 0;
        while (hs < 1 && c < 50) begin @(posedge clk); #1; c++; end
        chk("abort_first_word", hs, 1);
        begin
            rd_t r;
            r.chk = 1'b0; r.a = 2'd2; r.v = 32'h0;
            rq.push_back(r);
        end
        cpu_valid = 1'b1; cpu_addr = 2'd2; cpu_wdata = 32'h1; cpu_wstrb = 4'hF;
        @(posedge clk); #1;
        cpu_valid = 1'b0; cpu_wstrb = 4'h0;
        chk("abort_sram_valid", sram_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        aq.delete();
        @(posedge clk); #1;
        cpu_rd(2'd3, mem(32'h700));
        cpu_rd(2'd2, 32'h0);
        credits = 100000;

        // Randomized scans with random wait states.
        wait_rnd = 1'b1;
        for (int k = 0; k < 8; k++) begin
            logic [31:0] b, e;
            int n;
            b = $urandom;
            n = $urandom_range(0, 10);
            e = ($urandom_range(0, 1) == 1) ? sum_of(b, n) : $urandom;
            scan_start(b, n, e);
            scan_finish(-1);
        end
        wait_rnd = 1'b0;

        // Reset mid-scan after two words, with the SRAM stalled.
        credits = 2;
        scan_start(32'h800, 4, 32'h0);
        c = 0;
        while (hs < 2 && c < 50) begin @(posedge clk); #1; c++; end
        chk("pre_reset_words", hs, 2);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("rst_mid_sram_valid", sram_valid, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_done", done, 1'b0);
        chk("rst_mid_cpu_ready", cpu_ready, 1'b0);
        aq.delete();
        rq.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        credits = 100000;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) cpu_rd(i[1:0], 32'h0);

        repeat (3) @(posedge clk);
        chk("cpu_queue_left", rq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
